// File: rtl/cpu_run_controller.sv
// Run/step/halt sequencer generating a one-cycle clock-enable for the single-cycle CPU.
// Define CPU_CTRL_BREAKPOINT_EN to enable the PC breakpoint (BREAK state); otherwise it is never entered.
module cpu_run_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned RUN_DIV         = 4,
  parameter int unsigned PC_WIDTH        = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                RunSwitch,
  input  logic                StepButton,
  input  logic                HaltRequest,
  input  logic [PC_WIDTH-1:0] Pc,
  input  logic [PC_WIDTH-1:0] BreakAddr,
  input  logic                BreakEnable,
  output logic                CpuEnable,
  output logic [1:0]          State,
  output logic                Halted,
  output logic [23:0]         CycleCount
);

  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int unsigned CNT_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  state_t             state, state_nxt;
  logic               btn_meta, btn_sync, btn_stable, btn_stable_d;
  logic [DEB_W-1:0]   deb_cnt;
  logic               step_pulse;
  logic [DIV_W-1:0]   presc, presc_nxt;
  logic               skip_bp, skip_bp_nxt;
  logic               bp_hit, issue, fire;
  logic               cpu_en_d, halted_d;
  logic               cpu_en_q, halted_q;
  logic [CNT_W-1:0]   cycle_cnt;

  // Button synchroniser and debouncer; stable only follows after DEBOUNCE_CYCLES agreeing samples
  always_ff @(posedge Clock) begin
    if (Reset) begin
      btn_meta     <= 1'b0;
      btn_sync     <= 1'b0;
      btn_stable   <= 1'b0;
      btn_stable_d <= 1'b0;
      deb_cnt      <= '0;
    end else begin
      btn_meta     <= StepButton;
      btn_sync     <= btn_meta;
      btn_stable_d <= btn_stable;
      if (btn_sync == btn_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_stable <= btn_sync;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  assign step_pulse = btn_stable & ~btn_stable_d;
  assign issue      = (presc == DIV_W'(RUN_DIV - 1));

`ifdef CPU_CTRL_BREAKPOINT_EN
  assign bp_hit = BreakEnable && (Pc == BreakAddr);
`else
  logic bp_unused;
  assign bp_hit    = 1'b0;
  assign bp_unused = ^{Pc, BreakAddr, BreakEnable};
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic, prescaler and breakpoint-skip bookkeeping
  always_comb begin
    state_nxt   = state;
    presc_nxt   = presc;
    skip_bp_nxt = skip_bp;
    fire        = 1'b0;
    case (state)
      ST_IDLE: begin
        presc_nxt = '0;
        if (RunSwitch && !HaltRequest) begin
          state_nxt   = ST_RUN;
          skip_bp_nxt = 1'b1;
        end else if (step_pulse) begin
          state_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        if (HaltRequest || !RunSwitch) begin
          state_nxt = ST_IDLE;
          presc_nxt = '0;
        end else if (issue) begin
          presc_nxt = '0;
          if (bp_hit && !skip_bp) begin
            state_nxt = ST_BREAK;
          end else begin
            fire        = 1'b1;
            skip_bp_nxt = 1'b0;
          end
        end else begin
          presc_nxt = presc + DIV_W'(1);
        end
      end
      ST_STEP: state_nxt = ST_IDLE;
      ST_BREAK: begin
        if (step_pulse)      state_nxt = ST_STEP;
        else if (!RunSwitch) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; the enable coincides with the STEP state or follows a RUN issue point
  always_comb begin
    cpu_en_d = fire || (state_nxt == ST_STEP);
    halted_d = (state_nxt == ST_IDLE) || (state_nxt == ST_BREAK);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      presc     <= '0;
      skip_bp   <= 1'b0;
      cpu_en_q  <= 1'b0;
      halted_q  <= 1'b1;
      cycle_cnt <= '0;
    end else begin
      presc    <= presc_nxt;
      skip_bp  <= skip_bp_nxt;
      cpu_en_q <= cpu_en_d;
      halted_q <= halted_d;
      if (cpu_en_d) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  assign CpuEnable  = cpu_en_q;
  assign State      = state;
  assign Halted     = halted_q;
  assign CycleCount = cycle_cnt;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomised and directed bench for cpu_run_controller against a cycle-level behavioural model.
module tb_cpu_run_controller;

  localparam int unsigned DEB = 20;
  localparam int unsigned DIV = 4;
  localparam int unsigned PCW = 32;

  logic           Clock;
  logic           Reset, RunSwitch, StepButton, HaltRequest, BreakEnable;
  logic [PCW-1:0] Pc, BreakAddr;
  logic           CpuEnable, Halted;
  logic [1:0]     State;
  logic [23:0]    CycleCount;

  cpu_run_controller #(.DEBOUNCE_CYCLES(DEB), .RUN_DIV(DIV), .PC_WIDTH(PCW)) dut (
    .Clock(Clock), .Reset(Reset), .RunSwitch(RunSwitch), .StepButton(StepButton),
    .HaltRequest(HaltRequest), .Pc(Pc), .BreakAddr(BreakAddr), .BreakEnable(BreakEnable),
    .CpuEnable(CpuEnable), .State(State), .Halted(Halted), .CycleCount(CycleCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 run, 2 step, 3 break
  int          m_mode, m_phase, m_agree;
  bit          m_skip, m_s1, m_s2, m_stab, m_stab_d, m_en, m_halted;
  logic [23:0] m_count;

  task automatic model_step();
    bit pulse, hit, stab_n, fire;
    int nm;
    if (Reset) begin
      m_mode = 0; m_phase = 0; m_skip = 0; m_s1 = 0; m_s2 = 0; m_stab = 0; m_stab_d = 0;
      m_agree = 0; m_en = 0; m_halted = 1; m_count = '0;
      return;
    end
    pulse  = m_stab && !m_stab_d;
    stab_n = m_stab;
    if (m_s2 != m_stab) begin
      m_agree++;
      if (m_agree == int'(DEB)) begin
        stab_n  = m_s2;
        m_agree = 0;
      end
    end else begin
      m_agree = 0;
    end
`ifdef CPU_CTRL_BREAKPOINT_EN
    hit = BreakEnable && (Pc == BreakAddr);
`else
    hit = 0;
`endif
    fire = 0;
    nm   = m_mode;
    case (m_mode)
      0: if (RunSwitch && !HaltRequest) begin nm = 1; m_phase = 0; m_skip = 1; end
         else if (pulse) nm = 2;
      1: if (HaltRequest || !RunSwitch) begin nm = 0; m_phase = 0; end
         else if (m_phase == int'(DIV) - 1) begin
           m_phase = 0;
           if (hit && !m_skip) nm = 3;
           else begin fire = 1; m_skip = 0; end
         end else m_phase++;
      2: nm = 0;
      default: if (pulse) nm = 2; else if (!RunSwitch) nm = 0;
    endcase
    m_en = fire || (nm == 2);
    if (m_en) m_count = m_count + 24'd1;
    m_mode   = nm;
    m_halted = (nm == 0) || (nm == 3);
    m_stab_d = m_stab;
    m_stab   = stab_n;
    m_s2     = m_s1;
    m_s1     = StepButton;
  endtask

  // One clock: model update, output comparison, then the toy CPU advances its PC on each enable
  task automatic cycle();
    @(posedge Clock);
    model_step();
    #1;
    check("state",  32'(State),      32'(m_mode));
    check("cpu_en", 32'(CpuEnable),  32'(m_en));
    check("halted", 32'(Halted),     32'(m_halted));
    check("count",  32'(CycleCount), 32'(m_count));
    @(negedge Clock);
    if (CpuEnable) Pc = (Pc + 32'd4) & 32'h3F;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [23:0] base;
  int          hold;

  initial begin
    Reset = 1; RunSwitch = 0; StepButton = 0; HaltRequest = 0;
    Pc = '0; BreakAddr = '0; BreakEnable = 0;
    @(negedge Clock);
    run_n(3);
    check("rst_state", 32'(State), 32'd0);
    check("rst_halted", 32'(Halted), 32'd1);
    check("rst_count", 32'(CycleCount), 32'd0);
    check("rst_en", 32'(CpuEnable), 32'd0);

    // Free run: entry edge plus 40 cycles gives ten pulses
    Reset = 0; RunSwitch = 1;
    run_n(41);
    check("run_count", 32'(CycleCount), 32'd10);
    check("run_state", 32'(State), 32'd1);
    RunSwitch = 0;
    run_n(3);

    // Bouncing button followed by a clean press yields one step
    base = m_count;
    for (int k = 0; k < 3; k++) begin
      StepButton = 1; run_n(5);
      StepButton = 0; run_n(5);
    end
    StepButton = 1; run_n(30);
    StepButton = 0; run_n(30);
    check("step_once", 32'(CycleCount), 32'(base + 24'd1));
    check("step_idle", 32'(State), 32'd0);

    // Halt exactly on the issue cycle
    RunSwitch = 1;
    run_n(4);
    base = m_count;
    HaltRequest = 1;
    run_n(1);
    check("halt_state", 32'(State), 32'd0);
    check("halt_en", 32'(CpuEnable), 32'd0);
    check("halt_count", 32'(CycleCount), 32'(base));
    HaltRequest = 0; RunSwitch = 0;
    run_n(2);

    // Reset while running with the prescaler at 2
    RunSwitch = 1;
    run_n(3);
    Reset = 1;
    run_n(1);
    check("rstrun_state", 32'(State), 32'd0);
    check("rstrun_en", 32'(CpuEnable), 32'd0);
    check("rstrun_count", 32'(CycleCount), 32'd0);
    Reset = 0; RunSwitch = 0;
    run_n(2);

    // Breakpoint at 0x0C with the PC stepping by 4 per enable
    Pc = '0; BreakAddr = 32'h0C; BreakEnable = 1; RunSwitch = 1;
    run_n(30);
`ifdef CPU_CTRL_BREAKPOINT_EN
    check("bp_state", 32'(State), 32'd3);
    check("bp_halted", 32'(Halted), 32'd1);
    check("bp_count", 32'(CycleCount), 32'd3);
`endif
    StepButton = 1; run_n(25);
    StepButton = 0; RunSwitch = 0; run_n(30);
    Pc = 32'h0C; RunSwitch = 1;
    run_n(6);
    check("bp_resume", 32'(State), 32'd1);
    RunSwitch = 0; BreakEnable = 0;
    run_n(3);

    // Count wrap from a preset value
    force dut.cycle_cnt = 24'hFFFFFE;
    m_count = 24'hFFFFFE;
    #1;
    release dut.cycle_cnt;
    RunSwitch = 1;
    run_n(10);
    check("wrap", 32'(CycleCount), 32'd0);
    RunSwitch = 0;
    run_n(3);

    // Random soak
    hold = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) RunSwitch = ~RunSwitch;
      HaltRequest = ($urandom_range(0, 15) == 0);
      hold--;
      if (hold <= 0) begin
        StepButton = ~StepButton;
        hold = int'($urandom_range(1, 40));
      end
      if ($urandom_range(0, 99) == 0) begin
        BreakEnable = ~BreakEnable;
        BreakAddr   = 32'($urandom_range(0, 15)) << 2;
      end
      Reset = ($urandom_range(0, 499) == 0);
      cycle();
    end
    Reset = 0;
    run_n(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences execution of the single-cycle CPU on the board by generating a one-cycle clock-enable for it.
- Supports free-run, single-step from a debounced push-button, external halt, and an optional PC breakpoint.
- Sits between the board switches/buttons and the CPU core, in the CPU's clock domain.
- Exports a 24-bit retired-instruction count sized for the six-digit seven-segment display path.

Parameters:
- DEBOUNCE_CYCLES, 20: consecutive stable samples required before StepButton is accepted (>=1).
- RUN_DIV, 4: in RUN, one CpuEnable pulse every RUN_DIV cycles (>=1; 1 = every cycle).
- PC_WIDTH, 32: width of Pc and BreakAddr.

Ports:
- Clock, input, 1: single clock; all state updates on rising edge.
- Reset, input, 1: synchronous, active-high reset.
- RunSwitch, input, 1: level; 1 requests free-run.
- StepButton, input, 1: raw asynchronous push-button; 2-flop synchronised internally.
- HaltRequest, input, 1: level; forces RUN back to IDLE.
- Pc, input, PC_WIDTH: current CPU program counter.
- BreakAddr, input, PC_WIDTH: breakpoint address.
- BreakEnable, input, 1: arms the breakpoint.
- CpuEnable, output, 1: registered; high exactly one cycle per instruction to execute.
- State, output, 2: registered FSM state (IDLE=00, RUN=01, STEP=10, BREAK=11).
- Halted, output, 1: registered; 1 when State is IDLE or BREAK.
- CycleCount, output, 24: registered count of CpuEnable pulses.

Behaviour:
- Reset (synchronous, active-high, Reset=1 at a rising edge):
  - State=IDLE, CpuEnable=0, Halted=1, CycleCount=0.
  - Prescaler=0, debounce counter=0, stable button level=0, skip_bp=0.
  - Reset mid-RUN or mid-STEP aborts any pending pulse.
- Debounce:
  - Counter increments while the synchronised button differs from the stable level; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable takes the synchronised value and the counter clears.
  - A 0->1 transition of stable produces step_pulse for exactly one cycle.
  - Press-to-step_pulse latency = 2 (sync) + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- IDLE:
  - RunSwitch=1 -> RUN; prescaler=0; skip_bp=1.
  - Else step_pulse -> STEP.
  - If both occur in the same cycle, RUN wins and step_pulse is dropped.
  - HaltRequest=1 blocks the transition to RUN; stepping is still allowed.
- RUN:
  - Prescaler counts 0..RUN_DIV-1 and wraps.
  - At prescaler==RUN_DIV-1 (issue point), check in priority order:
    1. HaltRequest=1 or RunSwitch=0 -> IDLE, no pulse.
    2. Breakpoint hit (see Optional Feature) and skip_bp=0 -> BREAK, no pulse.
    3. Otherwise CpuEnable=1 next cycle and skip_bp=0.
  - HaltRequest or RunSwitch=0 on a non-issue cycle also -> IDLE immediately and clears the prescaler.
- STEP: lasts exactly one cycle. CpuEnable=1 for one cycle, then -> IDLE. No breakpoint check in STEP.
- BREAK:
  - CpuEnable=0.
  - step_pulse -> STEP, which executes the instruction at BreakAddr.
  - RunSwitch 1->0 -> IDLE.
  - HaltRequest is ignored.
- CycleCount:
  - Increments by 1 in the same cycle CpuEnable is high.
  - Wraps 0xFFFFFF -> 0x000000 with no flag.
- CpuEnable is never high on two consecutive cycles unless RUN_DIV=1.

Optional Feature:
- Macro: CPU_CTRL_BREAKPOINT_EN.
- Defined: breakpoint hit = BreakEnable && (Pc == BreakAddr), evaluated at the RUN issue point. BREAK state is reachable.
- Undefined: hit is constant 0. BREAK (11) is unreachable, and State never shows 11. BreakAddr and BreakEnable remain as ports but are ignored.

Test Plan:
- Reset, then RunSwitch=1 with RUN_DIV=4 held for 40 cycles -> CpuEnable pulses every 4th cycle, 10 pulses total, CycleCount=10, State=01.
- StepButton bouncing (3 toggles of 5 cycles) then stable high for 30 cycles, DEBOUNCE_CYCLES=20 -> exactly one CpuEnable pulse, CycleCount +1, State returns to 00.
- RUN with HaltRequest=1 on the issue cycle -> no pulse that cycle, State=00 next cycle, CycleCount unchanged.
- CPU_CTRL_BREAKPOINT_EN defined, BreakEnable=1, BreakAddr=0x0000000C, Pc stepping 0,4,8,C -> 3 pulses, then State=11, Halted=1. A step press gives one pulse and State=00. RunSwitch toggle 0->1 resumes without re-breaking at 0x0C.
- CycleCount preset near wrap (run 0xFFFFFF pulses, or force in sim) -> one more pulse gives CycleCount=0x000000.
- Reset asserted while in RUN at prescaler=2 -> next cycle State=00, CpuEnable=0, CycleCount=0.
